// File: rtl/cpu_io_pkg.sv
// Shared constants and types for the cpu board-I/O conditioning blocks.
package cpu_io_pkg;

  localparam int SWITCH_WIDTH            = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 100000;

  // Per-bit debounce state, decoded from the qualification counter.
  typedef enum logic {
    DB_STABLE  = 1'b0,
    DB_PENDING = 1'b1
  } db_state_e;

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: 2-flop synchroniser, saturating stability counter and
// registered rise/fall pulse generation.
module switch_debounce_bit
  import cpu_io_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic change_next
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt, cnt_next;
  logic          level_next, rise_next, fall_next;
  db_state_e     state;

  assign state       = (cnt == '0) ? DB_STABLE : DB_PENDING;
  assign change_next = rise_next | fall_next;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves one unassigned and infers a latch.
    cnt_next   = cnt;
    level_next = level;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    unique case (state)
      DB_STABLE: begin
        if (sync2 != level) cnt_next = CNT_ONE;
      end
      DB_PENDING: begin
        if (sync2 == level) begin
          cnt_next = '0;
        end else if (cnt == CNT_MAX) begin
          level_next = sync2;
          cnt_next   = '0;
          rise_next  = sync2;
          fall_next  = ~sync2;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
    endcase
  end

  // Reset wins over an acceptance falling on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    if (!n_rst) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
      level <= RESET_VALUE;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      level <= level_next;
      cnt   <= cnt_next;
      rise  <= rise_next;
      fall  <= fall_next;
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Board-switch conditioning ahead of cpu.switch: per-bit synchronise and
// debounce, plus registered edge pulses and a combined change flag.
module switch_debouncer
  import cpu_io_pkg::*;
#(
  parameter int               WIDTH           = SWITCH_WIDTH,
  parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] switch_raw,
  output logic [WIDTH-1:0] switch,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  logic [WIDTH-1:0] change_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (RESET_VALUE[i])
    ) u_bit (
      .clk         (clk),
      .n_rst       (n_rst),
      .raw         (switch_raw[i]),
      .level       (switch[i]),
      .rise        (rise[i]),
      .fall        (fall[i]),
      .change_next (change_next[i])
    );
  end

  // Built from next-cycle pulses so it lands in the same cycle as rise/fall.
  always_ff @(posedge clk) begin
    if (!n_rst) any_change <= 1'b0;
    else        any_change <= |change_next;
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with a window-based reference model
// checked every cycle, plus hand-computed milestones.
module tb_switch_debouncer;

  localparam int         W  = 4;
  localparam int         D  = 4;
  localparam logic [W-1:0] RV = '0;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [W-1:0] switch_raw;
  logic [W-1:0] switch, rise, fall;
  logic         any_change;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  switch_debouncer #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D),
    .RESET_VALUE     (RV)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .switch_raw (switch_raw),
    .switch     (switch),
    .rise       (rise),
    .fall       (fall),
    .any_change (any_change)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an input becomes visible to qualification two edges
  // after it is sampled; a bit flips once the last D observations since
  // reset all disagree with its accepted level.
  logic [W-1:0] m_p1, m_p2, m_sw, m_rise, m_fall;
  logic         m_any;
  logic [W-1:0] obs_q[$];

  task automatic model_step();
    logic differs;
    if (!n_rst) begin
      m_p1 = RV; m_p2 = RV; m_sw = RV;
      m_rise = '0; m_fall = '0; m_any = 1'b0;
      obs_q.delete();
    end else begin
      obs_q.push_back(m_p2);
      if (obs_q.size() > D) void'(obs_q.pop_front());
      m_rise = '0;
      m_fall = '0;
      for (int b = 0; b < W; b++) begin
        differs = (obs_q.size() == D);
        for (int k = 0; k < obs_q.size(); k++)
          if (obs_q[k][b] == m_sw[b]) differs = 1'b0;
        if (differs) begin
          m_sw[b] = ~m_sw[b];
          if (m_sw[b]) m_rise[b] = 1'b1;
          else         m_fall[b] = 1'b1;
        end
      end
      m_any = |(m_rise | m_fall);
      m_p2 = m_p1;
      m_p1 = switch_raw;
    end
  endtask

  initial begin : compare_proc
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("switch",     switch,     m_sw);
      check("rise",       rise,       m_rise);
      check("fall",       fall,       m_fall);
      check("any_change", any_change, m_any);
    end
  end

  // Returns at the falling edge after n more rising edges.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : stim
    n_rst      = 1'b0;
    switch_raw = 4'b1111;
    edges(2);
    check("rst_switch", switch, 4'b0000);
    check("rst_rise",   rise,   4'b0000);
    check("rst_any",    any_change, 1'b0);

    // Leaving reset with raw = 1111: accepted at edge 5, no pulse earlier.
    n_rst = 1'b1;
    edges(5);
    check("post_rst_e4_switch", switch, 4'b0000);
    edges(1);
    check("post_rst_e5_switch", switch, 4'b1111);
    check("post_rst_e5_rise",   rise,   4'b1111);
    check("post_rst_e5_any",    any_change, 1'b1);
    edges(1);
    check("post_rst_e6_rise",   rise,   4'b0000);
    check("post_rst_e6_any",    any_change, 1'b0);

    switch_raw = 4'b0000;
    edges(10);
    check("all_low", switch, 4'b0000);

    // Clean edge on bit 0.
    switch_raw = 4'b0001;
    edges(5);
    check("clean_e4_sw0", switch[0], 1'b0);
    edges(1);
    check("clean_e5_sw0",   switch[0], 1'b1);
    check("clean_e5_rise0", rise[0],   1'b1);
    edges(1);
    check("clean_e6_rise0", rise[0],   1'b0);
    edges(3);
    switch_raw = 4'b0000;
    edges(6);
    check("clean_fall_e5",  fall[0],   1'b1);
    check("clean_fall_sw0", switch[0], 1'b0);
    edges(1);
    check("clean_fall_e6",  fall[0],   1'b0);
    edges(3);

    // Glitch on bit 1: 3 cycles rejected, then 4 cycles accepted.
    switch_raw = 4'b0010;
    edges(3);
    switch_raw = 4'b0000;
    edges(10);
    check("glitch_sw1", switch[1], 1'b0);
    switch_raw = 4'b0010;
    edges(4);
    switch_raw = 4'b0000;
    edges(2);
    check("pulse4_sw1",   switch[1], 1'b1);
    check("pulse4_rise1", rise[1],   1'b1);
    edges(10);
    check("pulse4_back", switch[1], 1'b0);

    // Bounce on bit 2: 1,0,1,1,1,1 ...
    switch_raw = 4'b0100;
    edges(1);
    switch_raw = 4'b0000;
    edges(1);
    switch_raw = 4'b0100;
    edges(5);
    check("bounce_e4_sw2", switch[2], 1'b0);
    edges(1);
    check("bounce_e5_sw2", switch[2], 1'b1);
    check("bounce_rise2",  rise[2],   1'b1);
    edges(3);

    // Bits 0 and 3 together, then bit 3 alone.
    switch_raw = 4'b1101;
    edges(6);
    check("indep_rise", rise, 4'b1001);
    check("indep_any",  any_change, 1'b1);
    check("indep_sw",   switch, 4'b1101);
    edges(1);
    check("indep_any_off", any_change, 1'b0);
    edges(2);
    switch_raw = 4'b0101;
    edges(6);
    check("indep_fall3", fall, 4'b1000);
    check("indep_rise0", rise, 4'b0000);
    check("indep_sw2",   switch, 4'b0101);
    edges(3);

    // Reset lands on the edge where bit 1 would have been accepted.
    switch_raw = 4'b0111;
    edges(5);
    n_rst = 1'b0;
    edges(1);
    check("midrst_sw",   switch, 4'b0000);
    check("midrst_rise", rise,   4'b0000);
    check("midrst_fall", fall,   4'b0000);
    check("midrst_any",  any_change, 1'b0);
    edges(1);
    n_rst = 1'b1;
    edges(5);
    check("midrst_e4_sw", switch, 4'b0000);
    edges(1);
    check("midrst_e5_sw",   switch, 4'b0111);
    check("midrst_e5_rise", rise,   4'b0111);
    edges(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
